// File: rtl/mac_seq_pkg.sv
// rtl/mac_seq_pkg.sv - shared state encoding, default widths and width helper for mac_sequencer
// Purpose: common definitions imported by mac_sequencer and mac_operand_buf.
// Contents: default parameter values, FSM state enum, index-width helper.
package mac_seq_pkg;

  localparam int DEF_DATA_W      = 8;
  localparam int DEF_RES_W       = 16;
  localparam int DEF_DEPTH       = 8;
  localparam int DEF_MAC_LATENCY = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_RUN    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // Bits needed to index n entries; never less than one so a depth of 1
  // still yields a legal vector.
  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mac_operand_buf.sv
// rtl/mac_operand_buf.sv - DEPTH x (ai,xi) operand register file, one write port, one async read port
// Purpose: holds the operand pairs of one MAC job.
// Ports:
//   clk              rising-edge clock
//   wr_en            write the pair at wr_addr this edge
//   wr_addr          write index
//   wr_ai / wr_xi    pair to store
//   rd_addr          read index
//   rd_ai / rd_xi    pair at rd_addr (combinational)
module mac_operand_buf #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_ai,
  input  logic [DATA_W-1:0] wr_xi,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_ai,
  output logic [DATA_W-1:0] rd_xi
);

  // No reset: stale entries are never read because the sequencer only
  // reads below its fill count, which reset clears.
  logic [2*DATA_W-1:0] mem_q [DEPTH];
  logic [2*DATA_W-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      mem_d[wr_addr] = {wr_ai, wr_xi};
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign {rd_ai, rd_xi} = mem_q[rd_addr];

endmodule

// File: rtl/mac_sequencer.sv
// rtl/mac_sequencer.sv - job sequencer feeding a sum-of-products MAC and capturing its result
// Purpose: buffers up to DEPTH (ai,xi) pairs, then on start clears the MAC,
//   streams the pairs (done on the last), waits MAC_LATENCY cycles and holds
//   the captured sum until result_ack.
// Ports:
//   clk, reset                        clock, synchronous active-high reset
//   load_valid/load_ready/load_ai/xi  operand pair loading (IDLE only)
//   start, hold                       job start (IDLE), streaming stall (RUN)
//   busy, count                       not idle, pairs buffered
//   mac_clear/enable/valid_in/done    MAC strobes
//   mac_ai, mac_xi, mac_result        MAC operand and result buses
//   result, result_valid, result_ack  captured sum handshake
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int DATA_W      = DEF_DATA_W,
  parameter int RES_W       = DEF_RES_W,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int MAC_LATENCY = DEF_MAC_LATENCY,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_valid,
  output logic              load_ready,
  input  logic [DATA_W-1:0] load_ai,
  input  logic [DATA_W-1:0] load_xi,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              mac_clear,
  output logic              mac_enable,
  output logic              mac_valid_in,
  output logic              mac_done,
  output logic [DATA_W-1:0] mac_ai,
  output logic [DATA_W-1:0] mac_xi,
  input  logic [RES_W-1:0]  mac_result,
  output logic [RES_W-1:0]  result,
  output logic              result_valid,
  input  logic              result_ack
);

  localparam int PTR_W = idx_width(DEPTH);
  localparam int LAT_W = idx_width(MAC_LATENCY);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LAT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RES_W-1:0]   result_q, result_d;

  logic               not_full;
  logic               load_fire;
  logic               last_pair;
  logic               wait_last;
  logic [DATA_W-1:0]  buf_ai, buf_xi;

  assign not_full  = (count_q < CNT_W'(DEPTH));
  assign load_fire = (state_q == ST_IDLE) && load_valid && not_full;
  assign last_pair = (CNT_W'(rd_ptr_q) == count_q - CNT_W'(1));
  assign wait_last = (wait_cnt_q == LAT_W'(MAC_LATENCY - 1));

  mac_operand_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_buf (
    .clk     (clk),
    .wr_en   (load_fire),
    .wr_addr (PTR_W'(count_q)),
    .wr_ai   (load_ai),
    .wr_xi   (load_xi),
    .rd_addr (rd_ptr_q),
    .rd_ai   (buf_ai),
    .rd_xi   (buf_xi)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wait_cnt_q <= '0;
      result_q   <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      result_q   <= result_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wait_cnt_d = '0;
    result_d   = result_q;
    case (state_q)
      ST_IDLE: begin
        if (load_fire) begin
          count_d = count_q + CNT_W'(1);
        end
        if (start) begin
          // A pair accepted in the same cycle joins this job.
          if ((count_q != '0) || load_fire) begin
            state_d = ST_CLEAR;
          end else begin
            state_d  = ST_RESULT;
            result_d = '0;
          end
        end
      end
      ST_CLEAR: begin
        rd_ptr_d = '0;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (!hold) begin
          if (last_pair) begin
            rd_ptr_d = '0;
            state_d  = ST_WAIT;
          end else begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
          end
        end
      end
      ST_WAIT: begin
        if (wait_last) begin
          result_d = mac_result;
          state_d  = ST_RESULT;
        end else begin
          wait_cnt_d = wait_cnt_q + LAT_W'(1);
        end
      end
      ST_RESULT: begin
        if (result_ack) begin
          count_d = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    load_ready   = 1'b0;
    busy         = 1'b1;
    mac_clear    = 1'b0;
    mac_enable   = 1'b0;
    mac_valid_in = 1'b0;
    mac_done     = 1'b0;
    mac_ai       = '0;
    mac_xi       = '0;
    result_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        busy       = 1'b0;
        load_ready = not_full;
      end
      ST_CLEAR: mac_clear = 1'b1;
      ST_RUN: begin
        // Operands stay on the bus during a hold; only the strobes drop.
        mac_ai = buf_ai;
        mac_xi = buf_xi;
        if (!hold) begin
          mac_enable   = 1'b1;
          mac_valid_in = 1'b1;
          mac_done     = last_pair;
        end
      end
      ST_WAIT:   mac_enable   = 1'b1;
      ST_RESULT: result_valid = 1'b1;
      default: ;
    endcase
  end

  assign count  = count_q;
  assign result = result_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb/tb_mac_sequencer.sv - directed self-checking bench for mac_sequencer with a two-stage MAC model
module tb_mac_sequencer;

  localparam int DATA_W = 8;
  localparam int RES_W  = 16;
  localparam int DEPTH  = 8;
  localparam int LAT    = 2;
  localparam int CNT_W  = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              load_valid = 1'b0;
  logic              load_ready;
  logic [DATA_W-1:0] load_ai = '0;
  logic [DATA_W-1:0] load_xi = '0;
  logic              start = 1'b0;
  logic              hold = 1'b0;
  logic              busy;
  logic [CNT_W-1:0]  count;
  logic              mac_clear, mac_enable, mac_valid_in, mac_done;
  logic [DATA_W-1:0] mac_ai, mac_xi;
  logic [RES_W-1:0]  mac_result;
  logic [RES_W-1:0]  result;
  logic              result_valid;
  logic              result_ack = 1'b0;

  int total = 0;
  int bad   = 0;
  int exp_a [8];
  int exp_x [8];

  always #5 clk = ~clk;

  mac_sequencer #(
    .DATA_W      (DATA_W),
    .RES_W       (RES_W),
    .DEPTH       (DEPTH),
    .MAC_LATENCY (LAT)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .load_valid   (load_valid),
    .load_ready   (load_ready),
    .load_ai      (load_ai),
    .load_xi      (load_xi),
    .start        (start),
    .hold         (hold),
    .busy         (busy),
    .count        (count),
    .mac_clear    (mac_clear),
    .mac_enable   (mac_enable),
    .mac_valid_in (mac_valid_in),
    .mac_done     (mac_done),
    .mac_ai       (mac_ai),
    .mac_xi       (mac_xi),
    .mac_result   (mac_result),
    .result       (result),
    .result_valid (result_valid),
    .result_ack   (result_ack)
  );

  // Product_Sum stand-in: accumulate, then one output register (latency 2).
  logic [RES_W-1:0] acc_q, res_q;
  always_ff @(posedge clk) begin
    if (reset || mac_clear) acc_q <= '0;
    else if (mac_enable && mac_valid_in) acc_q <= acc_q + RES_W'(mac_ai) * RES_W'(mac_xi);
    res_q <= reset ? '0 : acc_q;
  end
  assign mac_result = res_q;

  task automatic load_pair(input int a, input int x);
    load_valid = 1'b1;
    load_ai    = DATA_W'(a);
    load_xi    = DATA_W'(x);
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic run_job(input string name, input int n, input int hold_at, input int hold_len,
                         input bit inject, input logic [RES_W-1:0] exp_res);
    int c, pairs, clears, dones, done_at, held;
    bit got, order_ok, hold_ok, idle_ok;
    c = 1; pairs = 0; clears = 0; dones = 0; done_at = -1; held = 0;
    got = 0; order_ok = 1; hold_ok = 1; idle_ok = 1;
    start = 1'b1;
    @(posedge clk); #1;
    start = inject; load_valid = inject; load_ai = 8'hFF; load_xi = 8'hFF;
    while (c < 60 && !got) begin
      hold = (pairs == hold_at) && (held < hold_len);
      @(negedge clk);
      if (busy !== 1'b1 || load_ready !== 1'b0 || count !== CNT_W'(n)) idle_ok = 0;
      if (mac_clear) clears++;
      if (hold) begin
        if (mac_enable !== 1'b0 || mac_valid_in !== 1'b0 || mac_done !== 1'b0) hold_ok = 0;
        held++;
      end
      if (mac_valid_in) begin
        if (pairs >= n || mac_ai !== DATA_W'(exp_a[pairs]) || mac_xi !== DATA_W'(exp_x[pairs])) order_ok = 0;
        if (mac_done) begin dones++; done_at = pairs; end
        pairs++;
      end else if (mac_done) dones += 10;
      if (result_valid) got = 1;
      else begin @(posedge clk); #1; c++; end
    end
    hold = 1'b0;
    total++; if (!got) begin bad++; $display("FAIL %s timeout: no result_valid in %0d cycles", name, c); end
    total++; if (c !== 2 + n + LAT + hold_len) begin bad++; $display("FAIL %s latency: got %0d want %0d", name, c, 2 + n + LAT + hold_len); end
    total++; if (result !== exp_res) begin bad++; $display("FAIL %s result: got %0d want %0d", name, result, exp_res); end
    total++; if (clears !== 1) begin bad++; $display("FAIL %s clear pulses: got %0d want 1", name, clears); end
    total++; if (pairs !== n) begin bad++; $display("FAIL %s valid pairs: got %0d want %0d", name, pairs, n); end
    total++; if (dones !== 1 || done_at !== n - 1) begin bad++; $display("FAIL %s done: count %0d at pair %0d want 1 at %0d", name, dones, done_at, n - 1); end
    total++; if (!order_ok) begin bad++; $display("FAIL %s pair order: got out-of-order want buffered sequence", name); end
    total++; if (!hold_ok) begin bad++; $display("FAIL %s hold strobes: got active want 0", name); end
    total++; if (!idle_ok) begin bad++; $display("FAIL %s busy/count/load_ready while busy: got changed want stable", name); end
  endtask

  task automatic do_ack(input string name);
    result_ack = 1'b1;
    @(posedge clk); #1;
    result_ack = 1'b0;
    @(negedge clk);
    total++; if (result_valid !== 1'b0) begin bad++; $display("FAIL %s ack result_valid: got %b want 0", name, result_valid); end
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL %s ack load_ready: got %b want 1", name, load_ready); end
    total++; if (count !== '0) begin bad++; $display("FAIL %s ack count: got %0d want 0", name, count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL %s ack busy: got %b want 0", name, busy); end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    total++; if (load_ready !== 1'b1) begin bad++; $display("FAIL reset load_ready: got %b want 1", load_ready); end
    total++; if (count !== '0) begin bad++; $display("FAIL reset count: got %0d want 0", count); end
    total++; if ({busy, mac_clear, mac_enable, mac_valid_in, mac_done, result_valid} !== 6'b0)
      begin bad++; $display("FAIL reset strobes: got %b want 000000", {busy, mac_clear, mac_enable, mac_valid_in, mac_done, result_valid}); end
    total++; if ({mac_ai, mac_xi, result} !== '0) begin bad++; $display("FAIL reset buses: got %h want 0", {mac_ai, mac_xi, result}); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic_job();
    for (int i = 0; i < 4; i++) begin exp_a[i] = 2 * i + 1; exp_x[i] = 2 * i + 2; load_pair(2 * i + 1, 2 * i + 2); end
    run_job("basic", 4, -1, 0, 0, 16'd100);
    do_ack("basic");
  endtask

  task automatic test_hold();
    for (int i = 0; i < 4; i++) load_pair(2 * i + 1, 2 * i + 2);
    run_job("hold", 4, 2, 3, 0, 16'd100);
    do_ack("hold");
  endtask

  task automatic test_full_and_empty();
    for (int i = 0; i < 8; i++) begin exp_a[i] = 9; exp_x[i] = 10; load_pair(9, 10); end
    load_valid = 1'b1; load_ai = 8'd1; load_xi = 8'd1;
    @(negedge clk);
    total++; if (load_ready !== 1'b0) begin bad++; $display("FAIL full load_ready: got %b want 0", load_ready); end
    @(posedge clk); #1;
    load_valid = 1'b0;
    total++; if (count !== CNT_W'(8)) begin bad++; $display("FAIL full count: got %0d want 8", count); end
    run_job("full", 8, -1, 0, 0, 16'd720);
    do_ack("full");
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    total++; if (result_valid !== 1'b1 || result !== '0) begin bad++; $display("FAIL empty start: got valid=%b result=%0d want valid=1 result=0", result_valid, result); end
    total++; if (mac_valid_in !== 1'b0 || mac_clear !== 1'b0) begin bad++; $display("FAIL empty start MAC activity: got valid_in=%b clear=%b want 0 0", mac_valid_in, mac_clear); end
    do_ack("empty");
  endtask

  task automatic test_reset_mid_run();
    for (int i = 0; i < 4; i++) load_pair(2 * i + 1, 2 * i + 2);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    @(negedge clk);
    total++; if (mac_valid_in !== 1'b1 || mac_ai !== 8'd5) begin bad++; $display("FAIL abort third pair: got valid=%b ai=%0d want 1 5", mac_valid_in, mac_ai); end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || count !== '0 || mac_valid_in !== 1'b0 || load_ready !== 1'b1)
      begin bad++; $display("FAIL abort state: got busy=%b count=%0d valid=%b ready=%b want 0 0 0 1", busy, count, mac_valid_in, load_ready); end
    exp_a[0] = 11; exp_x[0] = 12;
    load_pair(11, 12);
    run_job("after_abort", 1, -1, 0, 0, 16'd132);
    do_ack("after_abort");
  endtask

  task automatic test_back_to_back_ignored();
    bit held_ok;
    held_ok = 1;
    exp_a[0] = 1; exp_x[0] = 1; exp_a[1] = 2; exp_x[1] = 3;
    load_pair(1, 1);
    load_valid = 1'b1; load_ai = 8'd2; load_xi = 8'd3;
    run_job("same_cycle", 2, -1, 0, 1, 16'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      if (result_valid !== 1'b1 || result !== 16'd7 || load_ready !== 1'b0 || count !== CNT_W'(2)) held_ok = 0;
    end
    total++; if (!held_ok) begin bad++; $display("FAIL result hold: got changed want result=7 held with load/start ignored"); end
    start = 1'b0; load_valid = 1'b0;
    do_ack("hold_ack");
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_hold();
    test_full_and_empty();
    test_reset_mid_run();
    test_back_to_back_ignored();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
